dispatch_stage: RTL and testbench
=================================

DISPATCH_STAGE -- requirements
Module: dispatch_stage

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- XLEN, 32, operand/immediate width
- REG_W, 5, architectural register index width
- ROB_W, 4, ROB tag width; tag 0 means "no dependency", valid tags are 1..2^ROB_W-1
- OP_W, 6, opcode width
- CDB_N, 2, number of common-data-bus broadcast ports
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk_in, in, 1, the single clock
- rst_n_in, in, 1, asynchronous active-low reset
- rdy_in, in, 1, global enable; low freezes all state
- flush_in, in, 1, mispredict flush
- dec_valid_in / dec_ready_out, in/out, 1, decoder handshake
- dec_rs_in, dec_rt_in, dec_rd_in, in, REG_W, source and destination registers
- dec_imm_in, in, XLEN, immediate
- dec_opcode_in, in, OP_W, opcode (0 = NOP)
- dec_pc_in, in, XLEN, instruction PC
- rf_rs_out / rf_rt_out, out, REG_W, regfile lookup indices (equal to dec_rs_in / dec_rt_in)
- rf_rs_busy_in, rf_rt_busy_in, in, 1, register renamed
- rf_rs_val_in, rf_rt_val_in, in, XLEN, register values
- rf_rs_tag_in, rf_rt_tag_in, in, ROB_W, rename tags
- rob_rs_tag_out, rob_rt_tag_out, out, ROB_W, ROB lookup tags
- rob_rs_ready_in, rob_rt_ready_in, in, 1, ROB entry has a result
- rob_rs_val_in, rob_rt_val_in, in, XLEN, ROB results
- rob_tail_in, in, ROB_W, tag for the next allocation
- rob_full_in, in, 1, no free ROB entry
- rob_alloc_out, out, 1, ROB allocate pulse
- rob_opcode_out, rob_rd_out, rob_pc_out, out, OP_W/REG_W/XLEN, allocation payload
- rename_en_out, out, 1, regfile rename pulse
- rename_rd_out, out, REG_W, register to rename
- rename_tag_out, out, ROB_W, tag written into the regfile
- cdb_valid_in, in, CDB_N, broadcast valids
- cdb_tag_in, in, CDB_N*ROB_W, packed broadcast tags
- cdb_val_in, in, CDB_N*XLEN, packed broadcast values
- rs_valid_out / rs_ready_in, out/in, 1, reservation-station handshake
- rs_qj_out, rs_qk_out, out, ROB_W, pending tags
- rs_vj_out, rs_vk_out, out, XLEN, operand values
- rs_a_out, out, XLEN, immediate
- rs_dest_out, out, ROB_W, destination tag
- rs_opcode_out, out, OP_W, opcode
- rs_pc_out, out, XLEN, PC

Function
REQ-003 The block SHALL hold a single output packet register with two states: EMPTY (rs_valid_out=0) and FULL (rs_valid_out=1).
REQ-004 Acceptance SHALL be: accept = rdy_in & !flush_in & dec_valid_in & dec_ready_out.
REQ-005 dec_ready_out SHALL be: rdy_in & !rob_full_in & (EMPTY | rs_ready_in).
REQ-006 On accept of a non-NOP, the following SHALL be driven combinationally in the same cycle:
- rob_alloc_out=1, with opcode, rd and pc as payload.
- rename_en_out=1 only if dec_rd_in!=0, with rename_tag_out=rob_tail_in.
REQ-007 Each operand SHALL be resolved at accept in this priority:
1. Register 0: value 0, tag 0.
2. Regfile not busy: regfile value, tag 0.
3. Busy and the tag matches a valid CDB port this cycle: CDB value, tag 0. The lowest-index port wins.
4. Busy and ROB ready: ROB value, tag 0.
5. Otherwise: value 0, tag equal to the rename tag.
REQ-008 rob_rs_tag_out / rob_rt_tag_out SHALL equal rf_rs_tag_in / rf_rt_tag_in combinationally.
REQ-009 On accept, the output register SHALL load at the next edge and go FULL, with rs_dest_out=rob_tail_in. Operand latency is 1 cycle.
REQ-010 Throughput SHALL be one instruction per cycle: FULL with rs_ready_in=1 and an accept in the same cycle stays FULL with the new packet.
REQ-011 FULL with rs_ready_in=1 and no accept SHALL go EMPTY.
REQ-012 While FULL and not handed off, each cycle a nonzero rs_qj_out/rs_qk_out that matches a valid CDB tag SHALL capture that value into vj/vk and clear the tag to 0.
REQ-013 An accepted NOP SHALL be consumed with no alloc, no rename, and no output-register load.
REQ-014 A flush SHALL take effect as follows:
- flush_in=1 forces EMPTY at the next edge and suppresses accept, alloc and rename that cycle.
- A flush overrides a simultaneous rs handshake.
REQ-015 rdy_in=0 SHALL freeze all state and force the pulses and dec_ready_out to 0.
REQ-016 All outputs SHALL be stable while FULL and rs_ready_in=0, except for the REQ-012 operand updates.

Reset
REQ-017 rst_n_in low SHALL asynchronously force EMPTY and clear every registered output (values and tags) to 0.
REQ-018 Combinational pulses SHALL be 0 while rst_n_in is low.
REQ-019 After rst_n_in rises, the first accept SHALL be possible on the first edge.

Verification
REQ-020 Test: rs=3 not busy with value 0x11, rt=0 -> next cycle vj=0x11, qj=0, vk=0, qk=0, dest=rob_tail.
REQ-021 Test: rs busy with tag 5, ROB not ready, CDB0 broadcasts tag 5 with value 0x77 in the same cycle -> vj=0x77, qj=0.
REQ-022 Test: FULL with qk=6 held because rs_ready_in=0, CDB1 broadcasts tag 6 with value 0x9 -> next cycle qk=0, vk=0x9, and no other field changes.
REQ-023 Test: rob_full_in=1 -> dec_ready_out=0 and no alloc or rename.
REQ-024 Test: back-to-back accepts with rs_ready_in=1 every cycle -> 4 instructions in 4 cycles.
REQ-025 Test: flush_in while FULL with a concurrent dec_valid_in -> EMPTY next cycle, no alloc. Also assert rst_n_in mid-packet -> outputs are 0 immediately.

Source files
------------

// File: rtl/dispatch_stage.sv
// Dispatch stage: resolves operands from regfile/ROB/CDB, allocates ROB entries and
// renames destinations, and holds one packet for the reservation station.
module dispatch_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned REG_W = 5,
   parameter int unsigned ROB_W = 4,
   parameter int unsigned OP_W  = 6,
   parameter int unsigned CDB_N = 2
) (
   input  logic                     clk_in,
   input  logic                     rst_n_in,
   input  logic                     rdy_in,
   input  logic                     flush_in,
   input  logic                     dec_valid_in,
   output logic                     dec_ready_out,
   input  logic [REG_W-1:0]         dec_rs_in,
   input  logic [REG_W-1:0]         dec_rt_in,
   input  logic [REG_W-1:0]         dec_rd_in,
   input  logic [XLEN-1:0]          dec_imm_in,
   input  logic [OP_W-1:0]          dec_opcode_in,
   input  logic [XLEN-1:0]          dec_pc_in,
   output logic [REG_W-1:0]         rf_rs_out,
   output logic [REG_W-1:0]         rf_rt_out,
   input  logic                     rf_rs_busy_in,
   input  logic                     rf_rt_busy_in,
   input  logic [XLEN-1:0]          rf_rs_val_in,
   input  logic [XLEN-1:0]          rf_rt_val_in,
   input  logic [ROB_W-1:0]         rf_rs_tag_in,
   input  logic [ROB_W-1:0]         rf_rt_tag_in,
   output logic [ROB_W-1:0]         rob_rs_tag_out,
   output logic [ROB_W-1:0]         rob_rt_tag_out,
   input  logic                     rob_rs_ready_in,
   input  logic                     rob_rt_ready_in,
   input  logic [XLEN-1:0]          rob_rs_val_in,
   input  logic [XLEN-1:0]          rob_rt_val_in,
   input  logic [ROB_W-1:0]         rob_tail_in,
   input  logic                     rob_full_in,
   output logic                     rob_alloc_out,
   output logic [OP_W-1:0]          rob_opcode_out,
   output logic [REG_W-1:0]         rob_rd_out,
   output logic [XLEN-1:0]          rob_pc_out,
   output logic                     rename_en_out,
   output logic [REG_W-1:0]         rename_rd_out,
   output logic [ROB_W-1:0]         rename_tag_out,
   input  logic [CDB_N-1:0]         cdb_valid_in,
   input  logic [CDB_N*ROB_W-1:0]   cdb_tag_in,
   input  logic [CDB_N*XLEN-1:0]    cdb_val_in,
   output logic                     rs_valid_out,
   input  logic                     rs_ready_in,
   output logic [ROB_W-1:0]         rs_qj_out,
   output logic [ROB_W-1:0]         rs_qk_out,
   output logic [XLEN-1:0]          rs_vj_out,
   output logic [XLEN-1:0]          rs_vk_out,
   output logic [XLEN-1:0]          rs_a_out,
   output logic [ROB_W-1:0]         rs_dest_out,
   output logic [OP_W-1:0]          rs_opcode_out,
   output logic [XLEN-1:0]          rs_pc_out
);

   typedef enum logic {EMPTY, FULL} state_t;

   typedef struct packed {
      logic [OP_W-1:0]  opcode;
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  a;
      logic [XLEN-1:0]  vj;
      logic [XLEN-1:0]  vk;
      logic [ROB_W-1:0] qj;
      logic [ROB_W-1:0] qk;
      logic [ROB_W-1:0] dest;
   } pkt_t;

   typedef struct packed {
      logic [XLEN-1:0]  val;
      logic [ROB_W-1:0] tag;
   } opnd_t;

   typedef struct packed {
      logic            hit;
      logic [XLEN-1:0] val;
   } cdb_hit_t;

   state_t state_q, state_d;
   pkt_t   pkt_q, pkt_d;
   logic   accept, load;
   opnd_t  opj, opk;
   cdb_hit_t wj, wk;

   // Scan from the top so the lowest-index matching port ends up winning.
   function automatic cdb_hit_t cdb_lookup(input logic [ROB_W-1:0]       tag,
                                           input logic [CDB_N-1:0]       cv,
                                           input logic [CDB_N*ROB_W-1:0] ct,
                                           input logic [CDB_N*XLEN-1:0]  cd);
      cdb_hit_t r;
      r = '0;
      for (int i = int'(CDB_N) - 1; i >= 0; i--) begin
         if (cv[i] && ct[i*ROB_W +: ROB_W] == tag) begin
            r.hit = 1'b1;
            r.val = cd[i*XLEN +: XLEN];
         end
      end
      return r;
   endfunction

   function automatic opnd_t resolve(input logic [REG_W-1:0] r,
                                     input logic             busy,
                                     input logic [XLEN-1:0]  rf_val,
                                     input logic [ROB_W-1:0] rf_tag,
                                     input logic             rob_ready,
                                     input logic [XLEN-1:0]  rob_val,
                                     input cdb_hit_t         ch);
      opnd_t o;
      o = '0;
      if (r == '0) o = '0;
      else if (!busy) o.val = rf_val;
      else if (ch.hit) o.val = ch.val;
      else if (rob_ready) o.val = rob_val;
      else o.tag = rf_tag;
      return o;
   endfunction

   assign rf_rs_out      = dec_rs_in;
   assign rf_rt_out      = dec_rt_in;
   assign rob_rs_tag_out = rf_rs_tag_in;
   assign rob_rt_tag_out = rf_rt_tag_in;

   assign dec_ready_out = rst_n_in & rdy_in & ~rob_full_in & ((state_q == EMPTY) | rs_ready_in);
   assign accept        = rdy_in & ~flush_in & dec_valid_in & dec_ready_out;
   assign load          = accept & (|dec_opcode_in);

   assign rob_alloc_out  = load;
   assign rob_opcode_out = dec_opcode_in;
   assign rob_rd_out     = dec_rd_in;
   assign rob_pc_out     = dec_pc_in;
   assign rename_en_out  = load & (|dec_rd_in);
   assign rename_rd_out  = dec_rd_in;
   assign rename_tag_out = rob_tail_in;

   assign opj = resolve(dec_rs_in, rf_rs_busy_in, rf_rs_val_in, rf_rs_tag_in, rob_rs_ready_in,
                        rob_rs_val_in, cdb_lookup(rf_rs_tag_in, cdb_valid_in, cdb_tag_in, cdb_val_in));
   assign opk = resolve(dec_rt_in, rf_rt_busy_in, rf_rt_val_in, rf_rt_tag_in, rob_rt_ready_in,
                        rob_rt_val_in, cdb_lookup(rf_rt_tag_in, cdb_valid_in, cdb_tag_in, cdb_val_in));
   assign wj  = cdb_lookup(pkt_q.qj, cdb_valid_in, cdb_tag_in, cdb_val_in);
   assign wk  = cdb_lookup(pkt_q.qk, cdb_valid_in, cdb_tag_in, cdb_val_in);

   // Next state and packet: flush beats handoff, a new load beats the drain.
   always_comb begin
      state_d = state_q;
      pkt_d   = pkt_q;
      if (rdy_in) begin
         if (flush_in) begin
            state_d = EMPTY;
         end else begin
            if (state_q == FULL) begin
               if (rs_ready_in) begin
                  state_d = EMPTY;
               end else begin
                  if (pkt_q.qj != '0 && wj.hit) begin
                     pkt_d.qj = '0;
                     pkt_d.vj = wj.val;
                  end
                  if (pkt_q.qk != '0 && wk.hit) begin
                     pkt_d.qk = '0;
                     pkt_d.vk = wk.val;
                  end
               end
            end
            if (load) begin
               state_d      = FULL;
               pkt_d.opcode = dec_opcode_in;
               pkt_d.pc     = dec_pc_in;
               pkt_d.a      = dec_imm_in;
               pkt_d.vj     = opj.val;
               pkt_d.qj     = opj.tag;
               pkt_d.vk     = opk.val;
               pkt_d.qk     = opk.tag;
               pkt_d.dest   = rob_tail_in;
            end
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= EMPTY;
         pkt_q   <= '0;
      end else begin
         state_q <= state_d;
         pkt_q   <= pkt_d;
      end
   end

   assign rs_valid_out  = (state_q == FULL);
   assign rs_qj_out     = pkt_q.qj;
   assign rs_qk_out     = pkt_q.qk;
   assign rs_vj_out     = pkt_q.vj;
   assign rs_vk_out     = pkt_q.vk;
   assign rs_a_out      = pkt_q.a;
   assign rs_dest_out   = pkt_q.dest;
   assign rs_opcode_out = pkt_q.opcode;
   assign rs_pc_out     = pkt_q.pc;

endmodule

// File: tb/tb_dispatch_stage.sv
// Directed testbench for dispatch_stage: operand resolution, CDB wakeup, handshakes,
// flush and reset behaviour, with hand-computed expectations.
module tb_dispatch_stage;
   localparam int unsigned XLEN = 32, REG_W = 5, ROB_W = 4, OP_W = 6, CDB_N = 2;

   logic clk_in = 1'b0, rst_n_in, rdy_in, flush_in, dec_valid_in, dec_ready_out;
   logic [REG_W-1:0] dec_rs_in, dec_rt_in, dec_rd_in, rf_rs_out, rf_rt_out, rob_rd_out, rename_rd_out;
   logic [XLEN-1:0] dec_imm_in, dec_pc_in, rf_rs_val_in, rf_rt_val_in, rob_rs_val_in, rob_rt_val_in, rob_pc_out;
   logic [OP_W-1:0] dec_opcode_in, rob_opcode_out, rs_opcode_out;
   logic rf_rs_busy_in, rf_rt_busy_in, rob_rs_ready_in, rob_rt_ready_in, rob_full_in, rob_alloc_out, rename_en_out;
   logic [ROB_W-1:0] rf_rs_tag_in, rf_rt_tag_in, rob_rs_tag_out, rob_rt_tag_out, rob_tail_in, rename_tag_out;
   logic [CDB_N-1:0] cdb_valid_in;
   logic [CDB_N*ROB_W-1:0] cdb_tag_in;
   logic [CDB_N*XLEN-1:0] cdb_val_in;
   logic rs_valid_out, rs_ready_in;
   logic [ROB_W-1:0] rs_qj_out, rs_qk_out, rs_dest_out;
   logic [XLEN-1:0] rs_vj_out, rs_vk_out, rs_a_out, rs_pc_out;

   int vectors = 0, miscompares = 0;

   dispatch_stage #(.XLEN(XLEN), .REG_W(REG_W), .ROB_W(ROB_W), .OP_W(OP_W), .CDB_N(CDB_N)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
      .dec_valid_in(dec_valid_in), .dec_ready_out(dec_ready_out),
      .dec_rs_in(dec_rs_in), .dec_rt_in(dec_rt_in), .dec_rd_in(dec_rd_in),
      .dec_imm_in(dec_imm_in), .dec_opcode_in(dec_opcode_in), .dec_pc_in(dec_pc_in),
      .rf_rs_out(rf_rs_out), .rf_rt_out(rf_rt_out),
      .rf_rs_busy_in(rf_rs_busy_in), .rf_rt_busy_in(rf_rt_busy_in),
      .rf_rs_val_in(rf_rs_val_in), .rf_rt_val_in(rf_rt_val_in),
      .rf_rs_tag_in(rf_rs_tag_in), .rf_rt_tag_in(rf_rt_tag_in),
      .rob_rs_tag_out(rob_rs_tag_out), .rob_rt_tag_out(rob_rt_tag_out),
      .rob_rs_ready_in(rob_rs_ready_in), .rob_rt_ready_in(rob_rt_ready_in),
      .rob_rs_val_in(rob_rs_val_in), .rob_rt_val_in(rob_rt_val_in),
      .rob_tail_in(rob_tail_in), .rob_full_in(rob_full_in), .rob_alloc_out(rob_alloc_out),
      .rob_opcode_out(rob_opcode_out), .rob_rd_out(rob_rd_out), .rob_pc_out(rob_pc_out),
      .rename_en_out(rename_en_out), .rename_rd_out(rename_rd_out), .rename_tag_out(rename_tag_out),
      .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_val_in(cdb_val_in),
      .rs_valid_out(rs_valid_out), .rs_ready_in(rs_ready_in),
      .rs_qj_out(rs_qj_out), .rs_qk_out(rs_qk_out), .rs_vj_out(rs_vj_out), .rs_vk_out(rs_vk_out),
      .rs_a_out(rs_a_out), .rs_dest_out(rs_dest_out), .rs_opcode_out(rs_opcode_out), .rs_pc_out(rs_pc_out));

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle();
      rdy_in = 1'b1; flush_in = 1'b0; dec_valid_in = 1'b0;
      dec_rs_in = '0; dec_rt_in = '0; dec_rd_in = '0; dec_imm_in = '0; dec_opcode_in = '0; dec_pc_in = '0;
      rf_rs_busy_in = 1'b0; rf_rt_busy_in = 1'b0; rf_rs_val_in = '0; rf_rt_val_in = '0;
      rf_rs_tag_in = '0; rf_rt_tag_in = '0; rob_rs_ready_in = 1'b0; rob_rt_ready_in = 1'b0;
      rob_rs_val_in = '0; rob_rt_val_in = '0; rob_tail_in = '0; rob_full_in = 1'b0;
      cdb_valid_in = '0; cdb_tag_in = '0; cdb_val_in = '0; rs_ready_in = 1'b0;
   endtask

   // Simple instruction with both sources ready from the regfile.
   task automatic issue(input logic [REG_W-1:0] rs, input logic [XLEN-1:0] vs,
                        input logic [ROB_W-1:0] tail, input logic [XLEN-1:0] pc);
      dec_valid_in = 1'b1; dec_opcode_in = 6'h03; dec_rs_in = rs; dec_rt_in = '0; dec_rd_in = 5'd9;
      rf_rs_busy_in = 1'b0; rf_rs_val_in = vs; rob_tail_in = tail; dec_pc_in = pc; dec_imm_in = 32'h4;
   endtask

   task automatic test_reset();
      idle();
      rst_n_in = 1'b0;
      dec_valid_in = 1'b1; dec_opcode_in = 6'h01; dec_rd_in = 5'd3;
      #12;
      vectors++; if (rs_valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0h exp 0", rs_valid_out); end
      vectors++; if (rob_alloc_out !== 1'b0) begin miscompares++; $display("FAIL reset_alloc got %0h exp 0", rob_alloc_out); end
      vectors++; if (rename_en_out !== 1'b0) begin miscompares++; $display("FAIL reset_rename got %0h exp 0", rename_en_out); end
      vectors++; if (rs_dest_out !== 4'h0 || rs_vj_out !== 32'h0) begin miscompares++; $display("FAIL reset_fields got dest %0h vj %0h exp 0", rs_dest_out, rs_vj_out); end
      idle();
      @(negedge clk_in);
      rst_n_in = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      dec_valid_in = 1'b1; dec_opcode_in = 6'h05; dec_rs_in = 5'd3; dec_rt_in = 5'd0; dec_rd_in = 5'd7;
      dec_imm_in = 32'h100; dec_pc_in = 32'h40; rf_rs_busy_in = 1'b0; rf_rs_val_in = 32'h11;
      rf_rt_busy_in = 1'b1; rf_rt_val_in = 32'hdead; rf_rt_tag_in = 4'd4; rob_tail_in = 4'd2;
      #1;
      vectors++; if (dec_ready_out !== 1'b1) begin miscompares++; $display("FAIL basic_ready got %0h exp 1", dec_ready_out); end
      vectors++; if (rob_alloc_out !== 1'b1 || rob_pc_out !== 32'h40 || rob_opcode_out !== 6'h05) begin miscompares++; $display("FAIL basic_alloc got %0h pc %0h op %0h exp 1 40 5", rob_alloc_out, rob_pc_out, rob_opcode_out); end
      vectors++; if (rename_en_out !== 1'b1 || rename_tag_out !== 4'd2 || rename_rd_out !== 5'd7) begin miscompares++; $display("FAIL basic_rename got %0h tag %0h rd %0h exp 1 2 7", rename_en_out, rename_tag_out, rename_rd_out); end
      vectors++; if (rf_rs_out !== 5'd3) begin miscompares++; $display("FAIL basic_rf_idx got %0h exp 3", rf_rs_out); end
      tick();
      idle();
      vectors++; if (rs_valid_out !== 1'b1 || rs_dest_out !== 4'd2) begin miscompares++; $display("FAIL basic_valid got %0h dest %0h exp 1 2", rs_valid_out, rs_dest_out); end
      vectors++; if (rs_vj_out !== 32'h11 || rs_qj_out !== 4'd0) begin miscompares++; $display("FAIL basic_j got vj %0h qj %0h exp 11 0", rs_vj_out, rs_qj_out); end
      vectors++; if (rs_vk_out !== 32'h0 || rs_qk_out !== 4'd0) begin miscompares++; $display("FAIL basic_k got vk %0h qk %0h exp 0 0", rs_vk_out, rs_qk_out); end
      vectors++; if (rs_a_out !== 32'h100 || rs_pc_out !== 32'h40 || rs_opcode_out !== 6'h05) begin miscompares++; $display("FAIL basic_payload got a %0h pc %0h op %0h", rs_a_out, rs_pc_out, rs_opcode_out); end
      rs_ready_in = 1'b1;
      tick();
      vectors++; if (rs_valid_out !== 1'b0) begin miscompares++; $display("FAIL basic_drain got %0h exp 0", rs_valid_out); end
      idle();
   endtask

   task automatic test_cdb_forward();
      dec_valid_in = 1'b1; dec_opcode_in = 6'h07; dec_rs_in = 5'd4; dec_rt_in = 5'd6; dec_rd_in = 5'd0;
      rf_rs_busy_in = 1'b1; rf_rs_tag_in = 4'd5; rob_rs_ready_in = 1'b0; rob_rs_val_in = 32'h66;
      rf_rt_busy_in = 1'b1; rf_rt_tag_in = 4'd3; rob_rt_ready_in = 1'b1; rob_rt_val_in = 32'h33;
      cdb_valid_in = 2'b11; cdb_tag_in = {4'd5, 4'd5}; cdb_val_in = {32'h88, 32'h77};
      rob_tail_in = 4'd9;
      #1;
      vectors++; if (rob_rs_tag_out !== 4'd5 || rob_rt_tag_out !== 4'd3) begin miscompares++; $display("FAIL fwd_rob_tags got %0h %0h exp 5 3", rob_rs_tag_out, rob_rt_tag_out); end
      vectors++; if (rob_alloc_out !== 1'b1 || rename_en_out !== 1'b0) begin miscompares++; $display("FAIL fwd_rd0 got alloc %0h ren %0h exp 1 0", rob_alloc_out, rename_en_out); end
      tick();
      idle();
      vectors++; if (rs_vj_out !== 32'h77 || rs_qj_out !== 4'd0) begin miscompares++; $display("FAIL fwd_cdb got vj %0h qj %0h exp 77 0", rs_vj_out, rs_qj_out); end
      vectors++; if (rs_vk_out !== 32'h33 || rs_qk_out !== 4'd0) begin miscompares++; $display("FAIL fwd_rob got vk %0h qk %0h exp 33 0", rs_vk_out, rs_qk_out); end
      vectors++; if (rs_dest_out !== 4'd9) begin miscompares++; $display("FAIL fwd_dest got %0h exp 9", rs_dest_out); end
      rs_ready_in = 1'b1;
      tick();
      idle();
   endtask

   task automatic test_wakeup();
      dec_valid_in = 1'b1; dec_opcode_in = 6'h0a; dec_rs_in = 5'd1; dec_rt_in = 5'd2; dec_rd_in = 5'd8;
      rf_rs_val_in = 32'haa; rf_rt_busy_in = 1'b1; rf_rt_tag_in = 4'd6; rob_tail_in = 4'd3;
      dec_pc_in = 32'h80; dec_imm_in = 32'h12;
      tick();
      idle();
      vectors++; if (rs_qk_out !== 4'd6 || rs_vk_out !== 32'h0) begin miscompares++; $display("FAIL wake_pending got qk %0h vk %0h exp 6 0", rs_qk_out, rs_vk_out); end
      // Held by rs_ready_in=0; port 0 carries an unrelated tag
      cdb_valid_in = 2'b11; cdb_tag_in = {4'd6, 4'd7}; cdb_val_in = {32'h9, 32'h55};
      dec_valid_in = 1'b1; dec_opcode_in = 6'h01; dec_rd_in = 5'd4;
      #1;
      vectors++; if (dec_ready_out !== 1'b0 || rob_alloc_out !== 1'b0) begin miscompares++; $display("FAIL wake_stall got ready %0h alloc %0h exp 0 0", dec_ready_out, rob_alloc_out); end
      tick();
      idle();
      vectors++; if (rs_qk_out !== 4'd0 || rs_vk_out !== 32'h9) begin miscompares++; $display("FAIL wake_capture got qk %0h vk %0h exp 0 9", rs_qk_out, rs_vk_out); end
      vectors++; if (rs_valid_out !== 1'b1 || rs_vj_out !== 32'haa || rs_qj_out !== 4'd0 || rs_dest_out !== 4'd3 || rs_pc_out !== 32'h80 || rs_a_out !== 32'h12 || rs_opcode_out !== 6'h0a) begin miscompares++; $display("FAIL wake_stable got v %0h vj %0h dest %0h pc %0h", rs_valid_out, rs_vj_out, rs_dest_out, rs_pc_out); end
   endtask

   // Still FULL from test_wakeup: rdy_in=0 must freeze state even with a handshake.
   task automatic test_freeze();
      rdy_in = 1'b0; rs_ready_in = 1'b1; flush_in = 1'b1;
      dec_valid_in = 1'b1; dec_opcode_in = 6'h02; dec_rd_in = 5'd2;
      #1;
      vectors++; if (dec_ready_out !== 1'b0 || rob_alloc_out !== 1'b0 || rename_en_out !== 1'b0) begin miscompares++; $display("FAIL freeze_pulses got %0h %0h %0h exp 0", dec_ready_out, rob_alloc_out, rename_en_out); end
      tick();
      vectors++; if (rs_valid_out !== 1'b1 || rs_vk_out !== 32'h9) begin miscompares++; $display("FAIL freeze_hold got v %0h vk %0h exp 1 9", rs_valid_out, rs_vk_out); end
      idle();
      rs_ready_in = 1'b1;
      tick();
      idle();
   endtask

   task automatic test_rob_full();
      issue(5'd2, 32'h5, 4'd1, 32'h0);
      rob_full_in = 1'b1;
      #1;
      vectors++; if (dec_ready_out !== 1'b0 || rob_alloc_out !== 1'b0 || rename_en_out !== 1'b0) begin miscompares++; $display("FAIL robfull got ready %0h alloc %0h ren %0h exp 0", dec_ready_out, rob_alloc_out, rename_en_out); end
      tick();
      vectors++; if (rs_valid_out !== 1'b0) begin miscompares++; $display("FAIL robfull_empty got %0h exp 0", rs_valid_out); end
      idle();
   endtask

   task automatic test_nop();
      dec_valid_in = 1'b1; dec_opcode_in = 6'h00; dec_rd_in = 5'd5; dec_rs_in = 5'd1; rf_rs_val_in = 32'h3;
      #1;
      vectors++; if (dec_ready_out !== 1'b1 || rob_alloc_out !== 1'b0 || rename_en_out !== 1'b0) begin miscompares++; $display("FAIL nop_pulses got ready %0h alloc %0h ren %0h exp 1 0 0", dec_ready_out, rob_alloc_out, rename_en_out); end
      tick();
      vectors++; if (rs_valid_out !== 1'b0) begin miscompares++; $display("FAIL nop_noload got %0h exp 0", rs_valid_out); end
      idle();
   endtask

   task automatic test_back_to_back();
      int accepted = 0;
      rs_ready_in = 1'b1;
      for (int k = 0; k < 4; k++) begin
         issue(5'd1, 32'h10 + 32'(k), 4'(k + 1), 32'h200 + 32'(4 * k));
         rs_ready_in = 1'b1;
         #1;
         if (rob_alloc_out === 1'b1) accepted++;
         tick();
         vectors++; if (rs_valid_out !== 1'b1 || rs_vj_out !== 32'h10 + 32'(k) || rs_dest_out !== 4'(k + 1)) begin miscompares++; $display("FAIL b2b_%0d got v %0h vj %0h dest %0h exp 1 %0h %0h", k, rs_valid_out, rs_vj_out, rs_dest_out, 32'h10 + 32'(k), k + 1); end
      end
      vectors++; if (accepted != 4) begin miscompares++; $display("FAIL b2b_count got %0d exp 4", accepted); end
      idle();
      rs_ready_in = 1'b1;
      tick();
      vectors++; if (rs_valid_out !== 1'b0) begin miscompares++; $display("FAIL b2b_drain got %0h exp 0", rs_valid_out); end
      idle();
   endtask

   task automatic test_flush();
      issue(5'd2, 32'h21, 4'd5, 32'h300);
      tick();
      idle();
      vectors++; if (rs_valid_out !== 1'b1) begin miscompares++; $display("FAIL flush_setup got %0h exp 1", rs_valid_out); end
      issue(5'd3, 32'h22, 4'd6, 32'h304);
      flush_in = 1'b1; rs_ready_in = 1'b1;
      #1;
      vectors++; if (rob_alloc_out !== 1'b0 || rename_en_out !== 1'b0) begin miscompares++; $display("FAIL flush_pulses got alloc %0h ren %0h exp 0 0", rob_alloc_out, rename_en_out); end
      tick();
      idle();
      vectors++; if (rs_valid_out !== 1'b0) begin miscompares++; $display("FAIL flush_empty got %0h exp 0", rs_valid_out); end
      issue(5'd4, 32'h44, 4'd7, 32'h400);
      tick();
      idle();
      #2;
      rst_n_in = 1'b0;
      #1;
      vectors++; if (rs_valid_out !== 1'b0 || rs_vj_out !== 32'h0 || rs_dest_out !== 4'h0 || rs_pc_out !== 32'h0 || rs_a_out !== 32'h0) begin miscompares++; $display("FAIL midreset got v %0h vj %0h dest %0h pc %0h", rs_valid_out, rs_vj_out, rs_dest_out, rs_pc_out); end
      @(negedge clk_in);
      rst_n_in = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_cdb_forward();
      test_wakeup();
      test_freeze();
      test_rob_full();
      test_nop();
      test_back_to_back();
      test_flush();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
